// File: rtl/ysyx_22050854_lsu_pkg.sv
// Shared constants, MemOP and FSM encodings, and the alignment helper for the
// ysyx_22050854 load/store unit.
package ysyx_22050854_lsu_pkg;

  localparam int LSU_XLEN   = 64;
  localparam int LSU_MASK_W = LSU_XLEN / 8;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LD  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_LWU = 3'b110,
    OP_ILL = 3'b111
  } memop_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  // Access size comes from op[1:0]; legality of op 111 is checked separately.
  function automatic logic is_aligned(input logic [2:0] op, input logic [2:0] addr);
    case (op[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~addr[0];
      2'b10:   return addr[1:0] == 2'b00;
      default: return addr == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050854_lsu_align.sv
// Byte-lane steering for stores and extraction/extension of load data
// from an 8-byte-aligned bus word.
module ysyx_22050854_lsu_align
  import ysyx_22050854_lsu_pkg::*;
(
  input  logic [2:0]            op,
  input  logic [2:0]            off,
  input  logic [LSU_XLEN-1:0]   wdata,
  input  logic [LSU_XLEN-1:0]   rdata,
  output logic [LSU_XLEN-1:0]   wdata_lane,
  output logic [LSU_MASK_W-1:0] wmask,
  output logic [LSU_XLEN-1:0]   rdata_ext
);

  logic [5:0]          shamt;
  logic [LSU_XLEN-1:0] raw;

  assign shamt = {off, 3'b000};

  always_comb begin
    wdata_lane = wdata << shamt;
    raw        = rdata >> shamt;
    wmask      = '0;
    rdata_ext  = '0;

    case (op[1:0])
      2'b00:   wmask = 8'h01 << off;
      2'b01:   wmask = 8'h03 << off;
      2'b10:   wmask = 8'h0F << off;
      default: wmask = 8'hFF;
    endcase

    case (memop_e'(op))
      OP_LB:   rdata_ext = {{(LSU_XLEN-8){raw[7]}}, raw[7:0]};
      OP_LH:   rdata_ext = {{(LSU_XLEN-16){raw[15]}}, raw[15:0]};
      OP_LW:   rdata_ext = {{(LSU_XLEN-32){raw[31]}}, raw[31:0]};
      OP_LD:   rdata_ext = raw;
      OP_LBU:  rdata_ext = {{(LSU_XLEN-8){1'b0}}, raw[7:0]};
      OP_LHU:  rdata_ext = {{(LSU_XLEN-16){1'b0}}, raw[15:0]};
      OP_LWU:  rdata_ext = {{(LSU_XLEN-32){1'b0}}, raw[31:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050854_lsu.sv
// Load/store unit: holds the single-cycle core stalled while one valid/ready
// data-memory access is in flight, then returns aligned, extended load data.
module ysyx_22050854_lsu
  import ysyx_22050854_lsu_pkg::*;
#(
  parameter int XLEN   = LSU_XLEN,
  parameter int MASK_W = LSU_MASK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);

  lsu_state_e        state, state_nx;
  logic              we_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              err_q;
  logic [XLEN-1:0]   rdata_q;
  logic              req_ok;
  logic [XLEN-1:0]   lane_wdata;
  logic [MASK_W-1:0] lane_wmask;
  logic [XLEN-1:0]   load_ext;

  assign req_ok = (memop_e'(req_op) != OP_ILL) && is_aligned(req_op, req_addr[2:0]);

  ysyx_22050854_lsu_align u_align (
    .op         (op_q),
    .off        (addr_q[2:0]),
    .wdata      (wdata_q),
    .rdata      (mem_resp_rdata),
    .wdata_lane (lane_wdata),
    .wmask      (lane_wmask),
    .rdata_ext  (load_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req_valid) begin
        we_q    <= req_we;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= ~req_ok;
        if (!req_ok) rdata_q <= '0;
      end
      // resp_rdata holds between responses; stores and errors report 0
      if (state == S_REQ && mem_req_ready && we_q) rdata_q <= '0;
      if (state == S_WAIT && mem_resp_valid) rdata_q <= load_ext;
    end
  end

  always_comb begin
    state_nx      = state;
    stall         = 1'b0;
    resp_valid    = 1'b0;
    misalign      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          stall    = 1'b1;
          state_nx = req_ok ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_we    = we_q;
        mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
        mem_req_wdata = we_q ? lane_wdata : '0;
        mem_req_wmask = we_q ? lane_wmask : '0;
        if (mem_req_ready) state_nx = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) state_nx = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        misalign   = err_q;
        state_nx   = S_IDLE;
      end
    endcase

    if (rst) begin
      stall         = 1'b0;
      resp_valid    = 1'b0;
      misalign      = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;
    end
  end

  assign resp_rdata = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_ysyx_22050854_lsu.sv
// Self-checking bench for ysyx_22050854_lsu: directed cases plus randomized
// transactions compared cycle by cycle against a transaction-level model.
module tb_ysyx_22050854_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] last_rd = '0;

  always #5 clk = ~clk;

  ysyx_22050854_lsu #(.XLEN(64), .MASK_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .misalign       (misalign),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Checks outputs mid-cycle, then advances to just after the next rising edge.
  task automatic sample(input string tag, input bit e_st, input bit e_rv, input bit e_mis,
                        input logic [63:0] e_rd, input bit e_mv, input bit chk_bus,
                        input bit e_we, input logic [63:0] e_addr, input logic [63:0] e_wd,
                        input logic [7:0] e_wm);
    @(negedge clk);
    check({tag, ".stall"}, 64'(stall), 64'(e_st));
    check({tag, ".resp_valid"}, 64'(resp_valid), 64'(e_rv));
    check({tag, ".misalign"}, 64'(misalign), 64'(e_mis));
    check({tag, ".resp_rdata"}, resp_rdata, e_rd);
    check({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'(e_mv));
    if (chk_bus) begin
      check({tag, ".mem_req_we"}, 64'(mem_req_we), 64'(e_we));
      check({tag, ".mem_req_addr"}, mem_req_addr, e_addr);
      check({tag, ".mem_req_wmask"}, 64'(mem_req_wmask), 64'(e_wm));
      if (e_we || !e_mv) check({tag, ".mem_req_wdata"}, mem_req_wdata, e_wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_sample(input string tag, input logic [63:0] e_rd);
    sample(tag, 0, 0, 0, e_rd, 0, 1, 0, '0, '0, '0);
  endtask

  // One full instruction: model computes the expected bus beat and result.
  task automatic txn(input string tag, input bit we, input logic [2:0] op,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] rdata, input int unsigned rdly,
                     input int unsigned sdly);
    int unsigned nb, off;
    bit          err, sgn;
    logic [63:0] e_addr, e_wd, e_ld;
    logic [7:0]  e_wm;

    nb     = 1 << op[1:0];
    off    = addr % 8;
    err    = (op == 3'd7) || ((addr % nb) != 0);
    e_addr = addr - (addr % 8);
    e_wd   = '0;
    e_wm   = '0;
    e_ld   = '0;
    for (int i = 0; i < 8; i++) begin
      if (i + off < 8) e_wd[8*(i+off) +: 8] = wdata[8*i +: 8];
      if (i < nb) begin
        e_wm[i+off]    = we;
        e_ld[8*i +: 8] = rdata[8*(i+off) +: 8];
      end
    end
    sgn = (op <= 3'd2) && e_ld[8*nb-1];
    if (sgn) for (int i = 0; i < 64; i++) if (i >= 8*nb) e_ld[i] = 1'b1;

    req_valid = 1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    mem_req_ready = 0; mem_resp_valid = 0;

    if (err) begin
      sample({tag, ".req"}, 1, 0, 0, last_rd, 0, 0, 0, '0, '0, '0);
      last_rd = '0;
      mem_resp_valid = 1'($urandom);
      sample({tag, ".err"}, 0, 1, 1, last_rd, 0, 0, 0, '0, '0, '0);
    end else begin
      sample({tag, ".req"}, 1, 0, 0, last_rd, 0, 0, 0, '0, '0, '0);
      for (int unsigned k = 0; k <= rdly; k++) begin
        mem_req_ready  = (k == rdly);
        mem_resp_valid = 1'($urandom);
        sample({tag, ".bus"}, 1, 0, 0, last_rd, 1, 1, we, e_addr, e_wd, e_wm);
      end
      mem_req_ready = 0;
      if (!we) begin
        for (int unsigned k = 0; k <= sdly; k++) begin
          mem_resp_valid = (k == sdly);
          mem_resp_rdata = (k == sdly) ? rdata : {$urandom, $urandom};
          sample({tag, ".wait"}, 1, 0, 0, last_rd, 0, 0, 0, '0, '0, '0);
        end
        last_rd = e_ld;
      end else begin
        last_rd = '0;
      end
      mem_resp_valid = 1'($urandom);
      mem_resp_rdata = {$urandom, $urandom};
      sample({tag, ".done"}, 0, 1, 0, last_rd, 0, 0, 0, '0, '0, '0);
    end
    mem_resp_valid = 0;
    req_valid = 0;
    req_we    = 1'($urandom);
    req_op    = 3'($urandom);
    idle_sample({tag, ".idle"}, last_rd);
  endtask

  initial begin
    bit          we;
    logic [2:0]  op;
    logic [63:0] addr;

    rst = 1; req_valid = 0; req_we = 0; req_op = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    @(posedge clk); #1;
    idle_sample("rst0", '0);
    req_valid = 1; req_addr = 64'h8000_0000;
    idle_sample("rst1", '0);
    rst = 0; req_valid = 0;
    idle_sample("idle0", '0);

    txn("lw",  0, 3'd2, 64'h8000_0004, '0, 64'h8765_4321_0000_0000, 0, 0);
    check("lw.value", last_rd, 64'hFFFF_FFFF_8765_4321);
    txn("lbu", 0, 3'd4, 64'h8000_0007, '0, 64'hAB00_0000_0000_0000, 0, 0);
    check("lbu.value", last_rd, 64'h0000_0000_0000_00AB);
    txn("lb",  0, 3'd0, 64'h8000_0007, '0, 64'hAB00_0000_0000_0000, 0, 0);
    check("lb.value", last_rd, 64'hFFFF_FFFF_FFFF_FFAB);
    txn("sh",  1, 3'd1, 64'h8000_0002, 64'h1234, '0, 0, 0);
    txn("sd",  1, 3'd3, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, '0, 3, 0);
    txn("ld",  0, 3'd3, 64'h8000_0018, '0, 64'hFEDC_BA98_7654_3210, 1, 2);
    txn("lw_mis", 0, 3'd2, 64'h8000_0002, '0, '0, 0, 0);
    txn("ill", 0, 3'd7, 64'h8000_0008, '0, '0, 0, 0);

    // reset while a load waits for data; the late response must be dropped
    req_valid = 1; req_we = 0; req_op = 3'd3; req_addr = 64'h8000_0008;
    sample("rm.req", 1, 0, 0, last_rd, 0, 0, 0, '0, '0, '0);
    mem_req_ready = 1;
    sample("rm.acc", 1, 0, 0, last_rd, 1, 1, 0, 64'h8000_0008, '0, '0);
    mem_req_ready = 0; rst = 1; req_valid = 0;
    idle_sample("rm.rst", '0);
    rst = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h1111_2222_3333_4444;
    idle_sample("rm.stale", '0);
    mem_resp_valid = 0;
    last_rd = '0;
    txn("rm.lw", 0, 3'd2, 64'h8000_0020, '0, 64'h0000_0000_7654_3210, 0, 0);

    for (int n = 0; n < 200; n++) begin
      we   = 1'($urandom);
      op   = we ? (($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 3))) : 3'($urandom);
      addr = 64'h8000_0000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) addr = addr & ~64'((1 << op[1:0]) - 1);
      txn($sformatf("rnd%0d", n), we, op, addr, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
